// File: rtl/secded_pkg.sv
// Shared types and elaboration-time helpers for the SECDED pipelined decoder.
// The codeword puts check bit k at position 2^(k-1) and packs data into the remaining positions.
package secded_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_CORR   = 2'b01,
        ERR_UNCORR = 2'b10
    } err_t;

    // Hamming bits plus one overall parity bit for each legal data width.
    function automatic int ecc_w(input int dw);
        int w;
        case (dw)
            8:       w = 5;
            16:      w = 6;
            32:      w = 7;
            default: w = 8;
        endcase
        return w;
    endfunction

    // Codeword position of data bit idx: the idx-th position that is not a power of two.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 3; p < 256; p++) begin
            if ((p & (p - 1)) != 0) begin
                if ((cnt == idx) && (pos == 0)) begin
                    pos = p;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/secded_pipe_decoder_if.sv
// Beat stream into and out of the SECDED decoder; master drives beats in and accepts results.
interface secded_pipe_decoder_if
    import secded_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    localparam int ECC_W = ecc_w(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ECC_W-1:0]  in_ecc;
    logic [TAG_W-1:0]  in_tag;
    logic              corr_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [1:0]        out_err;
    logic [ECC_W-2:0]  out_syn;

    modport master (
        output in_valid, in_data, in_ecc, in_tag, corr_en, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err, out_syn
    );

    modport slave (
        input  in_valid, in_data, in_ecc, in_tag, corr_en, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err, out_syn
    );
endinterface

// File: rtl/secded_core.sv
// Combinational SECDED check: syndrome, parity mismatch, classification and optional single-bit repair.
module secded_core
    import secded_pkg::*;
#(
    parameter  int DATA_W  = 64,
    localparam int ECC_W   = ecc_w(DATA_W),
    localparam int SYN_W   = ECC_W - 1,
    localparam int MAX_POS = DATA_W + SYN_W
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [ECC_W-1:0]  ecc_i,
    input  logic              corr_en_i,
    output logic [DATA_W-1:0] data_o,
    output err_t              err_o,
    output logic [SYN_W-1:0]  syn_o
);
    logic [SYN_W-1:0][DATA_W-1:0] cover_s;
    logic [SYN_W-1:0]             hbits_s;
    logic [SYN_W-1:0]             syn_s;
    logic [DATA_W-1:0]            hit_s;
    logic                         pm_s;

    // Each data bit feeds the Hamming bits selected by its codeword position.
    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        localparam int POS = data_pos(i);
        for (genvar k = 0; k < SYN_W; k++) begin : g_chk
            assign cover_s[k][i] = POS[k] & data_i[i];
        end
        assign hit_s[i] = (syn_s == SYN_W'(POS));
    end

    for (genvar k = 0; k < SYN_W; k++) begin : g_hbit
        assign hbits_s[k] = ^cover_s[k];
    end

    assign syn_s = hbits_s ^ ecc_i[ECC_W-1:1];
    assign pm_s  = (^data_i) ^ (^ecc_i);
    assign syn_o = syn_s;

    // Classify the beat; a data-position hit is repaired only when correction is enabled.
    always_comb begin
        data_o = data_i;
        err_o  = ERR_NONE;
        if (syn_s == '0) begin
            err_o = pm_s ? ERR_CORR : ERR_NONE;
        end else if (!pm_s) begin
            err_o = ERR_UNCORR;
        end else if (syn_s > SYN_W'(MAX_POS)) begin
            err_o = ERR_UNCORR;
        end else begin
            err_o = ERR_CORR;
            if (corr_en_i) begin
                data_o = data_i ^ hit_s;
            end else begin
                data_o = data_i;
            end
        end
    end
endmodule

// File: rtl/secded_pipe_decoder.sv
// Two-stage valid/ready SECDED decoder with saturating error counters, first-error log and DED interrupt.
// S1 captures raw beats, S2 holds the decoded result driving the output side of the bus.
module secded_pipe_decoder
    import secded_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int TAG_W  = 4,
    parameter  int CNT_W  = 16,
    localparam int ECC_W  = ecc_w(DATA_W),
    localparam int SYN_W  = ECC_W - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    secded_pipe_decoder_if.slave  bus,
    input  logic                  clr_cnt_i,
    input  logic                  clr_log_i,
    output logic [CNT_W-1:0]      corr_cnt_o,
    output logic [CNT_W-1:0]      uncorr_cnt_o,
    output logic                  log_valid_o,
    output logic [1:0]            log_err_o,
    output logic [SYN_W-1:0]      log_syn_o,
    output logic [TAG_W-1:0]      log_tag_o,
    output logic                  ded_irq_o
);
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [ECC_W-1:0]  s1_ecc_q, s1_ecc_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic              s1_corr_en_q, s1_corr_en_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
    err_t              s2_err_q, s2_err_d;
    logic [SYN_W-1:0]  s2_syn_q, s2_syn_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;
    logic              log_valid_q, log_valid_d;
    err_t              log_err_q, log_err_d;
    logic [SYN_W-1:0]  log_syn_q, log_syn_d;
    logic [TAG_W-1:0]  log_tag_q, log_tag_d;
    logic              ded_irq_q, ded_irq_d;

    logic              s2_adv_s;
    logic              ready_s;
    logic              xfer_s;
    logic [DATA_W-1:0] core_data_s;
    err_t              core_err_s;
    logic [SYN_W-1:0]  core_syn_s;

    secded_core #(.DATA_W(DATA_W)) u_core (
        .data_i    (s1_data_q),
        .ecc_i     (s1_ecc_q),
        .corr_en_i (s1_corr_en_q),
        .data_o    (core_data_s),
        .err_o     (core_err_s),
        .syn_o     (core_syn_s)
    );

    assign s2_adv_s = !s2_valid_q || bus.out_ready;
    assign ready_s  = !s1_valid_q || s2_adv_s;
    assign xfer_s   = s2_valid_q && bus.out_ready;

    // Next state for the pipeline stages, counters, log and interrupt.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s1_ecc_d     = s1_ecc_q;
        s1_tag_d     = s1_tag_q;
        s1_corr_en_d = s1_corr_en_q;
        if (ready_s) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_data_d    = bus.in_data;
                s1_ecc_d     = bus.in_ecc;
                s1_tag_d     = bus.in_tag;
                s1_corr_en_d = bus.corr_en;
            end else begin
                s1_data_d = s1_data_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        s2_err_d   = s2_err_q;
        s2_syn_d   = s2_syn_q;
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = core_data_s;
                s2_tag_d  = s1_tag_q;
                s2_err_d  = core_err_s;
                s2_syn_d  = core_syn_s;
            end else begin
                s2_data_d = s2_data_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end

        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clr_cnt_i) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (xfer_s) begin
            if ((s2_err_q == ERR_CORR) && (corr_cnt_q != {CNT_W{1'b1}})) begin
                corr_cnt_d = corr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                corr_cnt_d = corr_cnt_q;
            end
            if ((s2_err_q == ERR_UNCORR) && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
                uncorr_cnt_d = uncorr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                uncorr_cnt_d = uncorr_cnt_q;
            end
        end else begin
            corr_cnt_d = corr_cnt_q;
        end

        // A coinciding clear still lets the new error in, so the log stays valid.
        log_valid_d = log_valid_q;
        log_err_d   = log_err_q;
        log_syn_d   = log_syn_q;
        log_tag_d   = log_tag_q;
        if (xfer_s && (s2_err_q != ERR_NONE) && (!log_valid_q || clr_log_i)) begin
            log_valid_d = 1'b1;
            log_err_d   = s2_err_q;
            log_syn_d   = s2_syn_q;
            log_tag_d   = s2_tag_q;
        end else if (clr_log_i) begin
            log_valid_d = 1'b0;
        end else begin
            log_valid_d = log_valid_q;
        end

        ded_irq_d = xfer_s && (s2_err_q == ERR_UNCORR);
    end

    // State registers, all cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_ecc_q     <= '0;
            s1_tag_q     <= '0;
            s1_corr_en_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_tag_q     <= '0;
            s2_err_q     <= ERR_NONE;
            s2_syn_q     <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            log_valid_q  <= 1'b0;
            log_err_q    <= ERR_NONE;
            log_syn_q    <= '0;
            log_tag_q    <= '0;
            ded_irq_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_ecc_q     <= s1_ecc_d;
            s1_tag_q     <= s1_tag_d;
            s1_corr_en_q <= s1_corr_en_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_tag_q     <= s2_tag_d;
            s2_err_q     <= s2_err_d;
            s2_syn_q     <= s2_syn_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
            log_valid_q  <= log_valid_d;
            log_err_q    <= log_err_d;
            log_syn_q    <= log_syn_d;
            log_tag_q    <= log_tag_d;
            ded_irq_q    <= ded_irq_d;
        end
    end

    assign bus.in_ready  = ready_s && !rst;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_tag   = s2_tag_q;
    assign bus.out_err   = s2_err_q;
    assign bus.out_syn   = s2_syn_q;
    assign corr_cnt_o    = corr_cnt_q;
    assign uncorr_cnt_o  = uncorr_cnt_q;
    assign log_valid_o   = log_valid_q;
    assign log_err_o     = log_err_q;
    assign log_syn_o     = log_syn_q;
    assign log_tag_o     = log_tag_q;
    assign ded_irq_o     = ded_irq_q;
endmodule

// File: tb/tb_secded_pipe_decoder.sv
// Directed bench for secded_pipe_decoder (DATA_W=64, CNT_W=4) with a position-XOR reference model.
module tb_secded_pipe_decoder;
    import secded_pkg::*;

    localparam int DW = 64;
    localparam int TW = 4;
    localparam int CW = 4;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_cnt = 1'b0;
    logic          clr_log = 1'b0;
    logic [CW-1:0] corr_cnt, uncorr_cnt;
    logic          log_valid;
    logic [1:0]    log_err;
    logic [SW-1:0] log_syn;
    logic [TW-1:0] log_tag;
    logic          ded_irq;

    secded_pipe_decoder_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    secded_pipe_decoder #(.DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .clr_cnt_i    (clr_cnt),
        .clr_log_i    (clr_log),
        .corr_cnt_o   (corr_cnt),
        .uncorr_cnt_o (uncorr_cnt),
        .log_valid_o  (log_valid),
        .log_err_o    (log_err),
        .log_syn_o    (log_syn),
        .log_tag_o    (log_tag),
        .ded_irq_o    (ded_irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode: syndrome is the XOR of the positions of all set codeword bits.
    function automatic void decode_model(input logic [63:0] d, input logic [7:0] e, input logic ce,
                                         output logic [63:0] od, output logic [1:0] oe, output logic [6:0] os);
        int syn;
        int par;
        int di;
        int posidx [128];
        syn = 0;
        par = 0;
        di  = 0;
        for (int p = 0; p < 128; p++) posidx[p] = -1;
        for (int p = 1; p <= 71; p++) begin
            logic b;
            if ((p & (p - 1)) == 0) begin
                b = e[$clog2(p) + 1];
            end else begin
                b = d[di];
                posidx[p] = di;
                di++;
            end
            if (b) syn = syn ^ p;
            par = par ^ int'(b);
        end
        par = par ^ int'(e[0]);
        od = d;
        os = syn[6:0];
        if (syn == 0 && par == 0)      oe = 2'b00;
        else if (syn == 0)             oe = 2'b01;
        else if (par == 0)             oe = 2'b10;
        else if (syn > 71)             oe = 2'b10;
        else begin
            oe = 2'b01;
            if (ce && posidx[syn] >= 0) od[posidx[syn]] = ~d[posidx[syn]];
        end
    endfunction

    function automatic logic [7:0] encode(input logic [63:0] d);
        logic [63:0] od;
        logic [1:0]  oe;
        logic [6:0]  os;
        decode_model(d, 8'h00, 1'b0, od, oe, os);
        return {os, (^d) ^ (^os)};
    endfunction

    typedef struct {
        logic [63:0] d;
        logic [1:0]  e;
        logic [6:0]  s;
        logic [3:0]  t;
    } beat_t;

    beat_t       exp_q [$];
    int          m_corr = 0, m_uncorr = 0;
    logic        m_lv = 1'b0, m_irq = 1'b0;
    logic [1:0]  m_lerr = 2'b00;
    logic [6:0]  m_lsyn = 7'd0;
    logic [3:0]  m_ltag = 4'd0;

    // Compare process: every falling edge, check outputs against the model and advance it.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_corr = 0; m_uncorr = 0; m_lv = 1'b0; m_irq = 1'b0;
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_out_data", bus.out_data, 0);
            check("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
            check("rst_log", {log_valid, log_err, log_syn, log_tag}, 0);
            check("rst_irq", ded_irq, 0);
        end else begin
            logic       xfer;
            logic [1:0] xerr;
            beat_t      h;
            beat_t      nb;
            xfer = 1'b0;
            xerr = 2'b00;
            check("corr_cnt", corr_cnt, m_corr);
            check("uncorr_cnt", uncorr_cnt, m_uncorr);
            check("log_valid", log_valid, m_lv);
            if (m_lv) check("log_fields", {log_err, log_syn, log_tag}, {m_lerr, m_lsyn, m_ltag});
            check("ded_irq", ded_irq, m_irq);
            m_irq = 1'b0;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", bus.out_valid, 0);
                end else begin
                    h = exp_q[0];
                    check("out_beat", {bus.out_data, bus.out_err, bus.out_syn, bus.out_tag}, {h.d, h.e, h.s, h.t});
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        xfer = 1'b1;
                        xerr = h.e;
                        if (h.e == 2'b01 && m_corr < 15) m_corr++;
                        if (h.e == 2'b10 && m_uncorr < 15) m_uncorr++;
                        m_irq = (h.e == 2'b10);
                        if (h.e != 2'b00 && (!m_lv || clr_log)) begin
                            m_lv = 1'b1; m_lerr = h.e; m_lsyn = h.s; m_ltag = h.t;
                        end
                    end
                end
            end
            if (clr_cnt) begin m_corr = 0; m_uncorr = 0; end
            if (clr_log && !(xfer && xerr != 2'b00)) m_lv = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                decode_model(bus.in_data, bus.in_ecc, bus.corr_en, nb.d, nb.e, nb.s);
                nb.t = bus.in_tag;
                exp_q.push_back(nb);
            end
            if (exp_q.size() > 2) check("occupancy", exp_q.size(), 2);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat (called just after a rising edge) and hold it until accepted.
    task automatic drive(input logic [63:0] d, input logic [7:0] e, input logic ce, input logic [3:0] t);
        logic acc;
        int   guard;
        guard = 0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_ecc = e; bus.corr_en = ce; bus.in_tag = t;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check("accept_timeout", acc, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_beat(input string nm, input logic [63:0] d, input logic [1:0] e,
                               input logic [6:0] s, input logic [3:0] t);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.out_valid && c < 20);
        check({nm, "_latency"}, c, 2);
        check({nm, "_data"}, bus.out_data, d);
        check({nm, "_err"}, bus.out_err, e);
        check({nm, "_syn"}, bus.out_syn, s);
        check({nm, "_tag"}, bus.out_tag, t);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [63:0] base [4];
    logic [63:0] dm   [8];
    logic [7:0]  em   [8];
    logic        cm   [8];
    logic [15:0] pat;
    logic [3:0]  tg;
    int          acc_n, irq_n;
    logic [3:0]  got [$];

    initial begin
        base = '{64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000001, 64'hDEADBEEF00C0FFEE};
        dm   = '{64'h0, 64'h8000000000000000, 64'h1, 64'h0, 64'h0, 64'h0000010000000020, 64'h0, 64'h0};
        em   = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h01, 8'h00, 8'hFE, 8'h91};
        cm   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        pat  = 16'b1011_0010_1110_0101;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ecc = '0; bus.in_tag = '0;
        bus.corr_en = 1'b0; bus.out_ready = 1'b1;

        idle(3);
        check("reset_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", bus.in_ready, 1);
        idle(1);
        check("model_encode_1", encode(64'h1), 8'h07);

        drive(64'h0, 8'h00, 1'b1, 4'd1);
        expect_beat("clean_zero", 64'h0, 2'b00, 7'd0, 4'd1);
        idle(2);
        drive(64'h1, 8'h00, 1'b1, 4'd2);
        expect_beat("single_corr", 64'h0, 2'b01, 7'd3, 4'd2);
        idle(2);
        check("corr_cnt_1", corr_cnt, 1);
        check("log_first", {log_valid, log_err, log_syn, log_tag}, {1'b1, 2'b01, 7'd3, 4'd2});
        drive(64'h1, 8'h00, 1'b0, 4'd3);
        expect_beat("single_report", 64'h1, 2'b01, 7'd3, 4'd3);
        idle(1);
        drive(64'h3, 8'h00, 1'b1, 4'd4);
        expect_beat("double", 64'h3, 2'b10, 7'd6, 4'd4);
        irq_n = 0;
        repeat (4) begin
            @(negedge clk);
            if (ded_irq) irq_n++;
        end
        check("ded_irq_pulses", irq_n, 1);
        check("uncorr_cnt_1", uncorr_cnt, 1);
        check("log_kept", log_syn, 7'd3);
        idle(1);

        tg = 4'd5;
        for (int v = 0; v < 2; v++) begin
            for (int j = 0; j < 8; j++) begin
                drive(base[v] ^ dm[j], encode(base[v]) ^ em[j], cm[j], tg);
                tg = tg + 4'd1;
            end
        end
        fork
            begin
                for (int v = 2; v < 4; v++) begin
                    for (int j = 0; j < 8; j++) begin
                        drive(base[v] ^ dm[j], encode(base[v]) ^ em[j], cm[j], tg);
                        tg = tg + 4'd1;
                    end
                end
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    bus.out_ready = pat[c % 16];
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        idle(6);

        bus.out_ready = 1'b0;
        acc_n = 0;
        tg = 4'd1;
        for (int c = 0; c < 6; c++) begin
            logic took;
            bus.in_valid = 1'b1; bus.in_tag = tg; bus.in_data = {60'h0, tg};
            bus.in_ecc = encode({60'h0, tg}); bus.corr_en = 1'b1;
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            if (took) begin acc_n++; tg = tg + 4'd1; end
        end
        check("bp_accepted", acc_n, 2);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_head_tag", bus.out_tag, 4'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic took;
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            if (bus.out_valid) got.push_back(bus.out_tag);
            @(posedge clk);
            #1;
            if (took) bus.in_valid = 1'b0;
        end
        check("bp_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) check("bp_order", got[i], i + 1);

        clr_cnt = 1'b1;
        idle(1);
        clr_cnt = 1'b0;
        @(negedge clk);
        check("cnt_cleared", {corr_cnt, uncorr_cnt}, 0);
        idle(1);
        for (int k = 0; k < 20; k++) begin
            logic [63:0] d;
            d = 64'h5A5A0000 + 64'(k);
            drive(d ^ (64'h1 << k), encode(d), 1'b1, 4'(k));
        end
        idle(4);
        check("corr_cnt_saturated", corr_cnt, 15);
        drive(64'h10, encode(64'h0), 1'b1, 4'd7);
        idle(1);
        clr_cnt = 1'b1;
        clr_log = 1'b1;
        idle(1);
        clr_cnt = 1'b0;
        clr_log = 1'b0;
        @(negedge clk);
        check("clr_wins", corr_cnt, 0);
        check("clr_log_with_err", {log_valid, log_err, log_tag}, {1'b1, 2'b01, 4'd7});
        idle(1);
        clr_log = 1'b1;
        idle(1);
        clr_log = 1'b0;
        @(negedge clk);
        check("log_cleared", log_valid, 0);
        idle(1);

        drive(64'hAA, encode(64'hAA), 1'b1, 4'd10);
        drive(64'hBB, encode(64'hBB), 1'b1, 4'd11);
        check("inflight_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("reset_kills_out", bus.out_valid, 0);
        check("reset_in_ready_low", bus.in_ready, 0);
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", bus.in_ready, 1);
        idle(1);
        drive(64'hCC, encode(64'hCC), 1'b1, 4'd12);
        expect_beat("post_reset", 64'hCC, 2'b00, 7'd0, 4'd12);
        idle(4);
        check("drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
